tas_pkt_tx: RTL and testbench

Serial packet transmitter for the temperature averaging system (tas) link. Accepts one packet (header byte plus 4 payload bytes) over a valid/ready handshake. Emits the packet as byte frames on serial_data/data_ena: LSB first, data_ena high for exactly 8 clocks per byte, with a programmable idle gap between bytes. Drives the tas input side: it is the stimulus source in system benches and the link driver in the ground-station model.

---
 rtl/tas_pkt_tx.sv | 261 ++++++++++++++++++++++++++
 tb/tb_tas_pkt_tx.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tas_pkt_tx.sv
// -----------------------------------------------------------------------------
// tas_pkt_tx
// Serial packet transmitter for the tas link. Accepts one packet (header byte
// plus 32-bit payload) on a valid/ready handshake and shifts it out as five
// byte frames, LSB first. data_ena is high for the 8 bit-clocks of each byte,
// and an idle gap of gap_cycles clocks (0 treated as 1) follows every byte,
// including the last one.
//
// Ports:
//   clk_50      in   1      clock, rising edge
//   reset_n     in   1      asynchronous active-low reset
//   pkt_valid   in   1      packet offered
//   pkt_ready   out  1      block can accept a packet (IDLE)
//   pkt_hdr     in   8      header byte, sent first
//   pkt_data    in   32     payload, [7:0] sent second ... [31:24] sent last
//   gap_cycles  in   GAP_W  idle clocks after each byte (0 -> 1)
//   serial_data out  1      serial bit, LSB first
//   data_ena    out  1      high during the 8 bit-clocks of each byte
//   busy        out  1      high from accept until return to IDLE
//   pkt_done    out  1      one-clock pulse on return to IDLE
//   exp_avg     out  8      (TAS_TX_EXPAVG_EN only) truncated mean of payload
//   exp_valid   out  1      (TAS_TX_EXPAVG_EN only) pulses with pkt_done when
//                           the header is HDR_A or HDR_B
//
// Optional feature macro: TAS_TX_EXPAVG_EN. When undefined, the HDR_A/HDR_B
// parameters, the exp_* ports and the averaging adder are all absent.
// All outputs are driven straight from flops.
// -----------------------------------------------------------------------------
module tas_pkt_tx #(
  parameter int GAP_W = 8
`ifdef TAS_TX_EXPAVG_EN
  ,
  parameter logic [7:0] HDR_A = 8'hA5,
  parameter logic [7:0] HDR_B = 8'hC3
`endif
) (
  input  logic             clk_50,
  input  logic             reset_n,
  input  logic             pkt_valid,
  output logic             pkt_ready,
  input  logic [7:0]       pkt_hdr,
  input  logic [31:0]      pkt_data,
  input  logic [GAP_W-1:0] gap_cycles,
  output logic             serial_data,
  output logic             data_ena,
  output logic             busy,
  output logic             pkt_done
`ifdef TAS_TX_EXPAVG_EN
  ,
  output logic [7:0]       exp_avg,
  output logic             exp_valid
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_bit_cnt;
  logic [2:0]       w_bit_cnt_nxt;
  logic [2:0]       r_byte_idx;
  logic [2:0]       w_byte_idx_nxt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [GAP_W-1:0] w_gap_cnt_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;

  // Packet contents captured at accept; later input changes are ignored.
  logic [31:0]      r_data;
  logic [GAP_W-1:0] r_gap_len;

  logic             r_pkt_ready;
  logic             r_serial_data;
  logic             r_data_ena;
  logic             r_busy;
  logic             r_pkt_done;

  logic             w_pkt_ready_nxt;
  logic             w_serial_data_nxt;
  logic             w_data_ena_nxt;
  logic             w_busy_nxt;
  logic             w_pkt_done_nxt;

  logic             w_accept;
  logic [GAP_W-1:0] w_gap_eff;

  assign w_accept  = (r_state == S_IDLE) && pkt_valid;
  assign w_gap_eff = (gap_cycles == '0) ? GAP_W'(1) : gap_cycles;

  // Payload byte that follows byte index idx (idx 0 is the header).
  function automatic logic [7:0] payload_byte(input logic [31:0] d,
                                              input logic [2:0]  idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = d[7:0];
      3'd1:    b = d[15:8];
      3'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // State register and control counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_byte_idx <= '0;
      r_gap_cnt  <= '0;
      r_shift    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_shift    <= w_shift_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_byte_idx_nxt = r_byte_idx;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_shift_nxt    = r_shift;
    case (r_state)
      S_IDLE: begin
        if (pkt_valid) begin
          w_state_nxt    = S_SHIFT;
          w_bit_cnt_nxt  = '0;
          w_byte_idx_nxt = '0;
          w_shift_nxt    = pkt_hdr;
        end
      end
      S_SHIFT: begin
        if (r_bit_cnt == 3'd7) begin
          w_state_nxt   = S_GAP;
          // Down-counter: GAP lasts exactly r_gap_len cycles (>= 1).
          w_gap_cnt_nxt = r_gap_len;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          w_shift_nxt   = r_shift >> 1;
        end
      end
      S_GAP: begin
        if (r_gap_cnt <= GAP_W'(1)) begin
          if (r_byte_idx < 3'd4) begin
            w_state_nxt    = S_SHIFT;
            w_bit_cnt_nxt  = '0;
            w_byte_idx_nxt = r_byte_idx + 3'd1;
            w_shift_nxt    = payload_byte(r_data, r_byte_idx);
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state, so the registered outputs line up with
  // the state they describe.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_data_ena_nxt    = (w_state_nxt == S_SHIFT);
    w_serial_data_nxt = (w_state_nxt == S_SHIFT) ? w_shift_nxt[0] : 1'b0;
    w_pkt_ready_nxt   = (w_state_nxt == S_IDLE);
    w_busy_nxt        = (w_state_nxt != S_IDLE);
    w_pkt_done_nxt    = (r_state != S_IDLE) && (w_state_nxt == S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_pkt_ready   <= 1'b1;
      r_serial_data <= 1'b0;
      r_data_ena    <= 1'b0;
      r_busy        <= 1'b0;
      r_pkt_done    <= 1'b0;
    end else begin
      r_pkt_ready   <= w_pkt_ready_nxt;
      r_serial_data <= w_serial_data_nxt;
      r_data_ena    <= w_data_ena_nxt;
      r_busy        <= w_busy_nxt;
      r_pkt_done    <= w_pkt_done_nxt;
    end
  end

  assign pkt_ready   = r_pkt_ready;
  assign serial_data = r_serial_data;
  assign data_ena    = r_data_ena;
  assign busy        = r_busy;
  assign pkt_done    = r_pkt_done;

  // ---------------------------------------------------------------------------
  // Packet capture (data only, no reset needed)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_50) begin
    if (w_accept) begin
      r_data    <= pkt_data;
      r_gap_len <= w_gap_eff;
    end
  end

`ifdef TAS_TX_EXPAVG_EN
  logic [7:0] r_avg_pend;
  logic       r_hdr_match;
  logic [7:0] r_exp_avg;
  logic       r_exp_valid;

  // Mean of the four payload bytes: 10-bit sum, truncating divide by 4.
  function automatic logic [7:0] avg4_trunc(input logic [31:0] d);
    logic [9:0] s;
    s = {2'b00, d[7:0]} + {2'b00, d[15:8]} + {2'b00, d[23:16]} + {2'b00, d[31:24]};
    return s[9:2];
  endfunction

  // ---------------------------------------------------------------------------
  // Average computed at accept, published on the pkt_done cycle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_50) begin
    if (w_accept) begin
      r_avg_pend  <= avg4_trunc(pkt_data);
      r_hdr_match <= (pkt_hdr == HDR_A) || (pkt_hdr == HDR_B);
    end
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_exp_avg   <= '0;
      r_exp_valid <= 1'b0;
    end else begin
      r_exp_valid <= w_pkt_done_nxt && r_hdr_match;
      if (w_pkt_done_nxt && r_hdr_match) begin
        r_exp_avg <= r_avg_pend;
      end
    end
  end

  assign exp_avg   = r_exp_avg;
  assign exp_valid = r_exp_valid;
`else
`endif

endmodule

// File: tb/tb_tas_pkt_tx.sv
// -----------------------------------------------------------------------------
// tb_tas_pkt_tx
// Scoreboard bench for tas_pkt_tx. The driver issues packets; at each accept
// the reference model expands the packet into its expected bit stream (with
// the cycle each bit must appear in) and the expected pkt_done cycle, and
// pushes them into queues. A negedge monitor pops and compares whenever the
// DUT shows data_ena or pkt_done, and checks pkt_ready/busy every cycle.
// Cycle numbering: the cycle following rising edge m is cycle m+1; an accept
// at edge k puts the first bit in cycle k+1.
// -----------------------------------------------------------------------------
module tb_tas_pkt_tx;

  logic        clk_50;
  logic        reset_n;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [7:0]  pkt_hdr;
  logic [31:0] pkt_data;
  logic [7:0]  gap_cycles;
  logic        serial_data;
  logic        data_ena;
  logic        busy;
  logic        pkt_done;
`ifdef TAS_TX_EXPAVG_EN
  logic [7:0]  exp_avg;
  logic        exp_valid;
`endif

  tas_pkt_tx dut (
    .clk_50      (clk_50),
    .reset_n     (reset_n),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .pkt_hdr     (pkt_hdr),
    .pkt_data    (pkt_data),
    .gap_cycles  (gap_cycles),
    .serial_data (serial_data),
    .data_ena    (data_ena),
    .busy        (busy),
    .pkt_done    (pkt_done)
`ifdef TAS_TX_EXPAVG_EN
    ,
    .exp_avg     (exp_avg),
    .exp_valid   (exp_valid)
`endif
  );

  typedef struct {
    int cyc;
    bit b;
  } exp_bit_t;

  typedef struct {
    int         cyc;
    bit         v;
    logic [7:0] avg;
  } exp_done_t;

  exp_bit_t  q_bits[$];
  exp_done_t q_done[$];

  int n_checks = 0;
  int n_err    = 0;
  int edge_n   = 0;
  int busy_from = 0;
  int idle_from = 0;
  int last_k    = 0;
  int last_g    = 1;
  logic [7:0] model_avg = 8'd0;

  initial begin
    clk_50 = 1'b0;
    forever #10 clk_50 = ~clk_50;
  end

  always @(posedge clk_50) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, edge_n + 1);
    end
  endtask

  task automatic flag(input string name, input int a, input int e);
    n_checks++;
    n_err++;
    $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, a, e, edge_n + 1);
  endtask

  // Offer one packet; accepted in the first cycle the model says the link is
  // idle. While waiting, junk is driven (valid held high when hold=1).
  task automatic send(input logic [7:0] hdr, input logic [31:0] data,
                      input logic [7:0] gap, input bit hold);
    int c;
    int g;
    int guard;
    int sum;
    logic [7:0] by [5];
    bit match;
    guard = 0;
    forever begin
      @(posedge clk_50);
      #1;
      c = edge_n + 1;
      if (c >= idle_from) begin
        pkt_valid  = 1'b1;
        pkt_hdr    = hdr;
        pkt_data   = data;
        gap_cycles = gap;
        g = (gap == 8'd0) ? 1 : int'(gap);
        by[0] = hdr;
        by[1] = data[7:0];
        by[2] = data[15:8];
        by[3] = data[23:16];
        by[4] = data[31:24];
        for (int b = 0; b < 5; b++)
          for (int i = 0; i < 8; i++)
            q_bits.push_back('{cyc: c + 1 + b * (8 + g) + i, b: by[b][i]});
        busy_from = c + 1;
        idle_from = c + 1 + 5 * (8 + g);
        last_k = c;
        last_g = g;
        sum = int'(by[1]) + int'(by[2]) + int'(by[3]) + int'(by[4]);
        match = (hdr == 8'hA5) || (hdr == 8'hC3);
        if (match) model_avg = 8'(sum / 4);
        q_done.push_back('{cyc: idle_from, v: match, avg: model_avg});
        break;
      end
      pkt_valid  = hold;
      pkt_hdr    = 8'($urandom);
      pkt_data   = $urandom;
      gap_cycles = 8'($urandom);
      guard++;
      if (guard > 3000) begin
        flag("send_timeout", guard, 0);
        break;
      end
    end
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      @(posedge clk_50);
      #1;
      pkt_valid  = 1'b0;
      pkt_hdr    = 8'($urandom);
      pkt_data   = $urandom;
      gap_cycles = 8'($urandom);
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    quiet(1);
    while (edge_n + 1 < idle_from + 2) begin
      quiet(1);
      guard++;
      if (guard > 3000) begin
        flag("idle_timeout", guard, 0);
        break;
      end
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk_50) begin : monitor
    int c;
    bit exp_rdy;
    exp_bit_t  eb;
    exp_done_t ed;
    if (reset_n) begin
      c = edge_n + 1;
      exp_rdy = !(c >= busy_from && c < idle_from);
      chk("pkt_ready", 32'(pkt_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(!exp_rdy));
      if (data_ena) begin
        if (q_bits.size() == 0) begin
          flag("unexpected_data_ena", c, 0);
        end else begin
          eb = q_bits.pop_front();
          chk("bit_cycle", 32'(c), 32'(eb.cyc));
          chk("serial_data", 32'(serial_data), 32'(eb.b));
        end
      end else begin
        chk("serial_idle", 32'(serial_data), 32'd0);
        if (q_bits.size() != 0 && q_bits[0].cyc <= c) begin
          flag("missing_bit", c, q_bits[0].cyc);
          void'(q_bits.pop_front());
        end
      end
      if (pkt_done) begin
        if (q_done.size() == 0) begin
          flag("unexpected_pkt_done", c, 0);
        end else begin
          ed = q_done.pop_front();
          chk("done_cycle", 32'(c), 32'(ed.cyc));
`ifdef TAS_TX_EXPAVG_EN
          chk("exp_valid", 32'(exp_valid), 32'(ed.v));
          chk("exp_avg", 32'(exp_avg), 32'(ed.avg));
`endif
        end
      end else begin
`ifdef TAS_TX_EXPAVG_EN
        chk("exp_valid_idle", 32'(exp_valid), 32'd0);
`endif
        if (q_done.size() != 0 && q_done[0].cyc <= c) begin
          flag("missing_pkt_done", c, q_done[0].cyc);
          void'(q_done.pop_front());
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(pkt_ready), 32'd1);
    chk({tag, "_serial"}, 32'(serial_data), 32'd0);
    chk({tag, "_ena"}, 32'(data_ena), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(pkt_done), 32'd0);
`ifdef TAS_TX_EXPAVG_EN
    chk({tag, "_exp_avg"}, 32'(exp_avg), 32'd0);
    chk({tag, "_exp_valid"}, 32'(exp_valid), 32'd0);
`endif
  endtask

  initial begin
    int target;
    int guard;
    reset_n    = 1'b1;
    pkt_valid  = 1'b0;
    pkt_hdr    = 8'h00;
    pkt_data   = 32'h0;
    gap_cycles = 8'h00;
    #3 reset_n = 1'b0;
    #4 check_reset_outputs("reset");
    repeat (3) @(posedge clk_50);
    #3 reset_n = 1'b1;
    @(negedge clk_50);
    check_reset_outputs("post_reset");

    // Test 1: basic packet, gap 4
    send(8'hA5, {8'h3C, 8'h43, 8'h55, 8'h3A}, 8'd4, 1'b0);
    wait_idle();

    // Test 2: gap 0 forced to 1, back-to-back packet on the pkt_done cycle
    send(8'hA5, {8'd40, 8'd30, 8'd20, 8'd10}, 8'd0, 1'b1);
    send(8'hC3, {8'd31, 8'd30, 8'd28, 8'd26}, 8'd0, 1'b1);
    wait_idle();

    // Test 3: non-temperature header, full serialization, average held
    send(8'h83, 32'hC3A5C3A5, 8'd2, 1'b0);
    wait_idle();

    // Test 4: valid held and inputs churning during transmission
    send(8'hA5, {8'd127, 8'd127, 8'd127, 8'd127}, 8'd3, 1'b1);
    send(8'hC3, $urandom, 8'd1, 1'b1);
    wait_idle();

    // Large gap boundary
    send(8'h5A, $urandom, 8'd255, 1'b0);
    wait_idle();

    // Test 5: reset during the 3rd byte aborts the packet
    send(8'hA5, 32'h12345678, 8'd5, 1'b0);
    target = last_k + 1 + 2 * (8 + last_g) + 3;
    guard = 0;
    while (edge_n + 1 < target && guard < 500) begin
      quiet(1);
      guard++;
    end
    #1;
    chk("abort_in_byte", 32'(data_ena), 32'd1);
    pkt_valid = 1'b0;
    reset_n   = 1'b0;
    q_bits.delete();
    q_done.delete();
    busy_from = 0;
    idle_from = 0;
    model_avg = 8'd0;
    #1 check_reset_outputs("abort");
    repeat (2) @(posedge clk_50);
    #5 reset_n = 1'b1;
    send(8'hC3, {8'd4, 8'd3, 8'd2, 8'd1}, 8'd2, 1'b0);
    wait_idle();

    // Randomized packets
    for (int n = 0; n < 25; n++) begin
      logic [7:0] h;
      case ($urandom_range(0, 3))
        0: h = 8'hA5;
        1: h = 8'hC3;
        default: h = 8'($urandom);
      endcase
      send(h, $urandom, 8'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) quiet($urandom_range(0, 3));
    end
    wait_idle();
    quiet(3);

    chk("bits_left", 32'(q_bits.size()), 32'd0);
    chk("done_left", 32'(q_done.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
